// File: rtl/umi_adder_pkg.sv
// Shared definitions for the UMI adder device and its host sequencer.
package umi_adder_pkg;

   // UMI opcodes (cmd[4:0])
   localparam logic [4:0] UMI_REQ_READ   = 5'h01;
   localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
   localparam logic [4:0] UMI_RESP_READ  = 5'h02;
   localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

   // Command field positions
   localparam int unsigned UMI_OPC_LSB  = 0;
   localparam int unsigned UMI_SIZE_LSB = 5;
   localparam int unsigned UMI_LEN_LSB  = 8;
   localparam int unsigned UMI_EOM_BIT  = 22;

   // Every transfer is a single 4-byte beat
   localparam logic [2:0] UMI_SIZE_4B = 3'd2;

   // Device register offsets
   localparam logic [63:0] REG_A = 64'h00;
   localparam logic [63:0] REG_B = 64'h08;
   localparam logic [63:0] REG_C = 64'h10;

   // Host sequencer state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WR_A   = 3'd1;
   localparam logic [2:0] ST_WAIT_A = 3'd2;
   localparam logic [2:0] ST_WR_B   = 3'd3;
   localparam logic [2:0] ST_WAIT_B = 3'd4;
   localparam logic [2:0] ST_RD_C   = 3'd5;
   localparam logic [2:0] ST_WAIT_C = 3'd6;
   localparam logic [2:0] ST_DONE   = 3'd7;

   // Single-beat, end-of-message command word for the given opcode
   function automatic logic [31:0] umi_cmd(input logic [4:0] opcode);
      logic [31:0] cmd;
      cmd = '0;
      cmd[UMI_OPC_LSB +: 5]  = opcode;
      cmd[UMI_SIZE_LSB +: 3] = UMI_SIZE_4B;
      cmd[UMI_LEN_LSB +: 8]  = 8'd0;
      cmd[UMI_EOM_BIT]       = 1'b1;
      return cmd;
   endfunction

endpackage

// File: rtl/umi_adder_host_timer.sv
// Wait-state watchdog: counts stalled cycles and flags the last allowed one.
module umi_adder_host_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic nreset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

   logic [CNTW-1:0] count_q;

   // Counter restarts whenever clear is held, advances on each enabled cycle
   always_ff @(posedge clk) begin
      if (!nreset || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Expired in the TIMEOUT-th stalled cycle so the wait lasts exactly TIMEOUT cycles
   always_comb begin
      expired = (count_q >= CNTW'(TIMEOUT - 1));
   end

endmodule

// File: rtl/umi_adder_host.sv
// Host sequencer: writes A and B to the UMI adder, reads back the sum.
module umi_adder_host
   import umi_adder_pkg::*;
#(
   parameter int unsigned   CW      = 32,
   parameter int unsigned   AW      = 64,
   parameter int unsigned   DW      = 32,
   parameter logic [AW-1:0] BASE    = '0,
   parameter logic [AW-1:0] SRCADDR = '0,
   parameter int unsigned   TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          op_valid,
   input  logic [DW-1:0] op_a,
   input  logic [DW-1:0] op_b,
   output logic          op_ready,
   output logic          res_valid,
   output logic [DW-1:0] res_sum,
   output logic          res_err,
   input  logic          res_ready,
   output logic          uhost_req_valid,
   output logic [CW-1:0] uhost_req_cmd,
   output logic [AW-1:0] uhost_req_dstaddr,
   output logic [AW-1:0] uhost_req_srcaddr,
   output logic [DW-1:0] uhost_req_data,
   input  logic          uhost_req_ready,
   input  logic          uhost_resp_valid,
   input  logic [CW-1:0] uhost_resp_cmd,
   input  logic [DW-1:0] uhost_resp_data,
   output logic          uhost_resp_ready
);

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] sum_q, sum_d;
   logic          err_q, err_d;
   logic          in_wait;
   logic          expired;
   logic [4:0]    resp_opc;
   logic          unused_resp_cmd;

   assign resp_opc        = uhost_resp_cmd[4:0];
   assign unused_resp_cmd = ^uhost_resp_cmd[CW-1:5];
   assign in_wait         = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B) ||
                            (state_q == ST_WAIT_C);

   // Counter is held clear outside wait states, so every wait starts from zero
   umi_adder_host_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .nreset  (nreset),
      .clear   (!in_wait),
      .enable  (in_wait && !uhost_resp_valid),
      .expired (expired)
   );

   // Next-state logic; a response beats a coincident timeout
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               sum_d   = '0;
               err_d   = 1'b0;
               state_d = ST_WR_A;
            end
         end
         ST_WR_A: if (uhost_req_ready) state_d = ST_WAIT_A;
         ST_WR_B: if (uhost_req_ready) state_d = ST_WAIT_B;
         ST_RD_C: if (uhost_req_ready) state_d = ST_WAIT_C;
         ST_WAIT_A: begin
            if (uhost_resp_valid) begin
               if (resp_opc != UMI_RESP_WRITE) err_d = 1'b1;
               state_d = ST_WR_B;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT_B: begin
            if (uhost_resp_valid) begin
               if (resp_opc != UMI_RESP_WRITE) err_d = 1'b1;
               state_d = ST_RD_C;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT_C: begin
            if (uhost_resp_valid) begin
               if (resp_opc != UMI_RESP_READ) err_d = 1'b1;
               sum_d   = uhost_resp_data;
               state_d = ST_DONE;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: if (res_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from registers only; request fields hold while stalled
   always_comb begin
      op_ready          = (state_q == ST_IDLE);
      res_valid         = (state_q == ST_DONE);
      res_sum           = sum_q;
      res_err           = err_q;
      uhost_resp_ready  = in_wait;
      uhost_req_srcaddr = SRCADDR;
      uhost_req_valid   = 1'b0;
      uhost_req_cmd     = '0;
      uhost_req_dstaddr = '0;
      uhost_req_data    = '0;
      case (state_q)
         ST_WR_A: begin
            uhost_req_valid   = 1'b1;
            uhost_req_cmd     = CW'(umi_cmd(UMI_REQ_WRITE));
            uhost_req_dstaddr = BASE + AW'(REG_A);
            uhost_req_data    = a_q;
         end
         ST_WR_B: begin
            uhost_req_valid   = 1'b1;
            uhost_req_cmd     = CW'(umi_cmd(UMI_REQ_WRITE));
            uhost_req_dstaddr = BASE + AW'(REG_B);
            uhost_req_data    = b_q;
         end
         ST_RD_C: begin
            uhost_req_valid   = 1'b1;
            uhost_req_cmd     = CW'(umi_cmd(UMI_REQ_READ));
            uhost_req_dstaddr = BASE + AW'(REG_C);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_umi_adder_host.sv
// Self-checking bench for umi_adder_host with a behavioural adder device.
module tb_umi_adder_host;

   localparam logic [63:0] BASE = 64'h0000_0000_4000_1000;
   localparam logic [63:0] SRC  = 64'hABCD_0000_0000_0042;
   localparam int unsigned TMO  = 15;

   // Expected command words: eom bit 22, size 2 at [7:5], opcode at [4:0]
   localparam logic [31:0] CMD_WR      = 32'h0040_0043;
   localparam logic [31:0] CMD_RD      = 32'h0040_0041;
   localparam logic [31:0] CMD_RESP_WR = 32'h0040_0044;
   localparam logic [31:0] CMD_RESP_RD = 32'h0040_0042;

   logic        clk = 1'b0;
   logic        nreset;
   logic        op_valid, op_ready, res_valid, res_err, res_ready;
   logic [31:0] op_a, op_b, res_sum;
   logic        req_valid, req_ready, resp_valid, resp_ready;
   logic [31:0] req_cmd, req_data, resp_cmd, resp_data;
   logic [63:0] req_dst, req_src;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] cmd;
      logic [63:0] dst;
      logic [63:0] src;
      logic [31:0] data;
   } req_t;
   req_t reqlog[$];

   // Device behaviour controls
   bit dev_stall = 1'b0;
   bit bad_a     = 1'b0;
   bit drop_b    = 1'b0;
   bit drop_c    = 1'b0;

   logic [31:0] mem_a, mem_b;
   logic        pend;
   logic [1:0]  dly;

   always #5 clk = ~clk;

   umi_adder_host #(
      .CW      (32),
      .AW      (64),
      .DW      (32),
      .BASE    (BASE),
      .SRCADDR (SRC),
      .TIMEOUT (TMO)
   ) dut (
      .clk               (clk),
      .nreset            (nreset),
      .op_valid          (op_valid),
      .op_a              (op_a),
      .op_b              (op_b),
      .op_ready          (op_ready),
      .res_valid         (res_valid),
      .res_sum           (res_sum),
      .res_err           (res_err),
      .res_ready         (res_ready),
      .uhost_req_valid   (req_valid),
      .uhost_req_cmd     (req_cmd),
      .uhost_req_dstaddr (req_dst),
      .uhost_req_srcaddr (req_src),
      .uhost_req_data    (req_data),
      .uhost_req_ready   (req_ready),
      .uhost_resp_valid  (resp_valid),
      .uhost_resp_cmd    (resp_cmd),
      .uhost_resp_data   (resp_data),
      .uhost_resp_ready  (resp_ready)
   );

   // Registered adder device: answers the cycle after a request unless stalled or dropped
   always @(posedge clk) begin
      if (!nreset) begin
         resp_valid <= 1'b0;
         resp_cmd   <= '0;
         resp_data  <= '0;
         pend       <= 1'b0;
         dly        <= '0;
         req_ready  <= 1'b1;
      end else begin
         req_ready <= dev_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (resp_valid && resp_ready) resp_valid <= 1'b0;
         if (pend) begin
            if (dly == 2'd0) begin
               resp_valid <= 1'b1;
               pend       <= 1'b0;
            end else begin
               dly <= dly - 2'd1;
            end
         end
         if (req_valid && req_ready) begin
            reqlog.push_back({req_cmd, req_dst, req_src, req_data});
            if (req_cmd[4:0] == 5'h03) begin
               if (req_dst == BASE) mem_a <= req_data;
               if (req_dst == BASE + 64'h8) mem_b <= req_data;
               resp_cmd  <= (bad_a && req_dst == BASE) ? CMD_RESP_RD : CMD_RESP_WR;
               resp_data <= '0;
            end else begin
               resp_cmd  <= CMD_RESP_RD;
               resp_data <= mem_a + mem_b;
            end
            if (!((drop_b && req_dst == BASE + 64'h8) || (drop_c && req_cmd[4:0] == 5'h01))) begin
               if (dev_stall && $urandom_range(0, 1) == 1) begin
                  pend <= 1'b1;
                  dly  <= 2'($urandom_range(0, 2));
               end else begin
                  resp_valid <= 1'b1;
               end
            end
         end
      end
   end

   // Request fields must hold while valid is stalled
   logic        p_nrst, p_vld, p_rdy;
   logic [31:0] p_cmd, p_data;
   logic [63:0] p_dst;
   always @(negedge clk) begin
      if (nreset && p_nrst && p_vld && !p_rdy) begin
         checks <= checks + 1;
         if (req_valid !== 1'b1 || req_cmd !== p_cmd || req_dst !== p_dst ||
             req_data !== p_data) begin
            failures <= failures + 1;
            $display("FAIL req_stable: got v=%b cmd=%h dst=%h data=%h want v=1 cmd=%h dst=%h data=%h",
                     req_valid, req_cmd, req_dst, req_data, p_cmd, p_dst, p_data);
         end
      end
      p_nrst <= nreset;
      p_vld  <= req_valid;
      p_rdy  <= req_ready;
      p_cmd  <= req_cmd;
      p_dst  <= req_dst;
      p_data <= req_data;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " op_ready"},  64'(op_ready),   64'd1);
      chk({tag, " res_valid"}, 64'(res_valid),  64'd0);
      chk({tag, " res_sum"},   64'(res_sum),    64'd0);
      chk({tag, " res_err"},   64'(res_err),    64'd0);
      chk({tag, " req_valid"}, 64'(req_valid),  64'd0);
      chk({tag, " req_cmd"},   64'(req_cmd),    64'd0);
      chk({tag, " req_dst"},   req_dst,         64'd0);
      chk({tag, " req_data"},  64'(req_data),   64'd0);
      chk({tag, " req_src"},   req_src,         SRC);
      chk({tag, " resp_rdy"},  64'(resp_ready), 64'd0);
   endtask

   // One full operation; exp_lat/exp_wait < 0 skip those checks
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_sum, input logic exp_err, input int exp_nreq,
                         input int exp_lat, input int exp_wait, input bit hold);
      int n;
      int waits;
      bit rdy_bad;
      bit hold_bad;
      logic [31:0] held;
      req_t exp_q[3];
      reqlog.delete();
      @(negedge clk);
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      n = 0;
      while (!op_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, " op_ready"}, 64'(op_ready), 64'd1);
      @(negedge clk);
      op_valid = 1'b0;
      n        = 1;
      waits    = 0;
      rdy_bad  = 1'b0;
      while (!res_valid && n < 400) begin
         if (op_ready) rdy_bad = 1'b1;
         if (resp_ready) waits++;
         @(negedge clk);
         n++;
      end
      chk({name, " res_valid"}, 64'(res_valid), 64'd1);
      if (exp_lat >= 0) chk({name, " latency"}, 64'(n), 64'(exp_lat));
      if (exp_wait >= 0) chk({name, " wait_cycles"}, 64'(waits), 64'(exp_wait));
      chk({name, " op_ready_busy"}, 64'(rdy_bad), 64'd0);
      chk({name, " res_sum"}, 64'(res_sum), 64'(exp_sum));
      chk({name, " res_err"}, 64'(res_err), 64'(exp_err));
      if (hold) begin
         held     = res_sum;
         hold_bad = 1'b0;
         repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_sum !== held || op_ready !== 1'b0) hold_bad = 1'b1;
         end
         chk({name, " res_hold"}, 64'(hold_bad), 64'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({name, " op_ready_after"},  64'(op_ready),  64'd1);
      chk({name, " res_valid_after"}, 64'(res_valid), 64'd0);
      exp_q[0] = {CMD_WR, BASE,          SRC, a};
      exp_q[1] = {CMD_WR, BASE + 64'h8,  SRC, b};
      exp_q[2] = {CMD_RD, BASE + 64'h10, SRC, 32'h0};
      chk({name, " nreq"}, 64'(reqlog.size()), 64'(exp_nreq));
      for (int i = 0; i < exp_nreq && i < reqlog.size(); i++) begin
         chk({name, $sformatf(" req%0d_cmd", i)},  64'(reqlog[i].cmd),  64'(exp_q[i].cmd));
         chk({name, $sformatf(" req%0d_dst", i)},  reqlog[i].dst,       exp_q[i].dst);
         chk({name, $sformatf(" req%0d_src", i)},  reqlog[i].src,       exp_q[i].src);
         chk({name, $sformatf(" req%0d_data", i)}, 64'(reqlog[i].data), 64'(exp_q[i].data));
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      bit          hold;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] ra, rb;
      vecs[0] = '{32'd5,         32'd7,         32'd12,        1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0};
      vecs[2] = '{32'd0,         32'd0,         32'd0,         1'b0};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1};
      vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
      vecs[5] = '{32'hDEAD_BEEF, 32'd1,         32'hDEAD_BEF0, 1'b0};

      nreset    = 1'b0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      nreset = 1'b1;

      // Zero-wait device: 7-cycle latency, one cycle per wait state
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, 3, 7, 3,
                vecs[i].hold);
      end

      // Wrong opcode on write A: error flagged, sum still returned
      bad_a = 1'b1;
      run_op("bad_opc", 32'd20, 32'd22, 32'd42, 1'b1, 3, 7, 3, 1'b0);
      bad_a = 1'b0;

      // Missing write-B response: 1 cycle in WAIT_A plus 15 in WAIT_B, no read issued
      drop_b = 1'b1;
      run_op("timeout", 32'd9, 32'd10, 32'd0, 1'b1, 2, -1, 16, 1'b0);
      drop_b = 1'b0;

      // Random stalls on both device channels, periodic result back-pressure
      dev_stall = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op($sformatf("rnd%0d", i), ra, rb, ra + rb, 1'b0, 3, -1, -1, (i % 10) == 0);
      end
      dev_stall = 1'b0;

      // Reset while waiting for the sum
      reqlog.delete();
      drop_c = 1'b1;
      @(negedge clk);
      op_valid = 1'b1;
      op_a     = 32'd100;
      op_b     = 32'd1;
      @(negedge clk);
      op_valid = 1'b0;
      n = 0;
      while (!(resp_ready && reqlog.size() == 3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid in_wait_c", 64'(resp_ready && reqlog.size() == 3), 64'd1);
      nreset = 1'b0;
      @(negedge clk);
      check_reset("rst_mid");
      nreset = 1'b1;
      drop_c = 1'b0;
      run_op("after_rst", 32'd3, 32'd4, 32'd7, 1'b0, 3, 7, 3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
